key_tone_player: RTL
====================

KEY_TONE_PLAYER -- requirements
Module: key_tone_player

Interface
REQ-001 The module SHALL have parameter W, default 32, setting the width of the phase accumulator, period and duty.
REQ-002 The module SHALL have parameter BEEP_CYCLES, default 12_500_000, setting the beep length in clk cycles.
REQ-003 The module SHALL have parameter FREQ_BASE, default 8590, giving the period value after reset.
REQ-004 The module SHALL have parameter FREQ_STEP, default 17180, giving the pitch increment/decrement.
REQ-005 The module SHALL have parameter VOL_STEP, default 429496729, giving the duty increment/decrement and the reset duty.
REQ-006 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 The module SHALL have port key_flag, input, 1 bit: one-cycle debounced key event strobe.
REQ-009 The module SHALL have port key_value, input, 4 bits: debounced key levels, active-low, valid when key_flag=1.
REQ-010 The module SHALL have port buzzer, output, 1 bit: active-low buzzer drive.
REQ-011 The module SHALL have port busy, output, 1 bit: high while in state BEEP.
REQ-012 The module SHALL have port period, output, W bits: current pitch increment.
REQ-013 The module SHALL have port duty, output, W bits: current volume compare value.

Function
REQ-014 The FSM SHALL have exactly two states, IDLE and BEEP; busy=1 only in BEEP.
REQ-015 An event SHALL occur on a cycle with key_flag=1 and at least one key_value bit at 0; key_flag=1 with key_value=4'b1111 SHALL be ignored.
REQ-016 On simultaneous pressed bits, only the lowest-index pressed key SHALL act.
REQ-017 key[0] (volume up) SHALL set duty to duty+VOL_STEP, saturating at 2^W-1 with no wrap.
REQ-018 key[1] (volume down) SHALL set duty to duty-VOL_STEP, with floor VOL_STEP.
REQ-019 key[2] (pitch up) SHALL set period to period+FREQ_STEP, saturating at 2^W-1.
REQ-020 key[3] (pitch down) SHALL set period to period-FREQ_STEP, with floor FREQ_STEP.
REQ-021 Each event SHALL update period/duty on the clock edge where key_flag is sampled, and the FSM SHALL enter (or remain in) BEEP with the timer cleared to 0 on the same edge.
REQ-022 An event arriving in BEEP SHALL retrigger the beep: apply the key action and restart the full BEEP_CYCLES window.
REQ-023 In BEEP without an event, the timer SHALL increment each cycle; at timer=BEEP_CYCLES-1 the FSM SHALL return to IDLE and clear the timer, giving busy high for exactly BEEP_CYCLES cycles per untriggered beep.
REQ-024 The W-bit phase accumulator SHALL add period each cycle in BEEP, wrap modulo 2^W, and be held at 0 in IDLE.
REQ-025 The internal pwm SHALL be 1 when accumulator < duty.
REQ-026 buzzer SHALL equal NOT(pwm AND busy), registered, so buzzer reacts one cycle after the accumulator/state change.
REQ-027 period and duty SHALL hold their values across beeps; they change only on events or reset.
REQ-028 Arithmetic for saturation checks SHALL use W+1-bit compare so overflow/underflow is detected without wrap.

Reset
REQ-029 While rst=1, state SHALL be IDLE, timer=0, accumulator=0, period=FREQ_BASE, duty=VOL_STEP, busy=0 and buzzer=1, asynchronously.
REQ-030 Reset asserted mid-beep SHALL abort the beep immediately, with no further buzzer low pulses, and restore the REQ-029 values.
REQ-031 After rst deasserts, the first event SHALL be accepted on the first rising clk edge.

Verification (W=8, BEEP_CYCLES=10, FREQ_BASE=16, FREQ_STEP=16, VOL_STEP=64)
REQ-032 The bench SHALL check: reset → period=16, duty=64, buzzer=1, busy=0.
REQ-033 The bench SHALL check: key_flag with key_value=4'b1110 (vol up) pressed four times → duty 128, 192, 255, 255 (saturated), with busy high for 10 cycles after each press.
REQ-034 The bench SHALL check: key_value=4'b0111 pressed twice from reset → period stays 16 (floor); key_value=4'b1011 → period=32, and buzzer is low 4 of every 8 cycles at duty=128.
REQ-035 The bench SHALL check: key_value=4'b1100 → only the volume-up action applies (duty 64→128) and period is unchanged.
REQ-036 The bench SHALL check: a press at timer=7 during BEEP → busy stays high a further 10 cycles (total 18), and buzzer=1 the cycle after busy falls.
REQ-037 The bench SHALL check: rst pulsed at timer=5 → busy=0 and buzzer=1 without waiting for a clk edge, and period/duty return to 16/64.

Source files
------------

// File: rtl/key_tone_player.sv
// Key-driven tone player: debounced key events adjust pitch/volume and trigger
// a fixed-length PWM beep on an active-low buzzer.
module key_tone_player #(
  parameter int W           = 32,
  parameter int BEEP_CYCLES = 12_500_000,
  parameter int FREQ_BASE   = 8590,
  parameter int FREQ_STEP   = 17180,
  parameter int VOL_STEP    = 429496729
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_flag,
  input  logic [3:0]   key_value,
  output logic         buzzer,
  output logic         busy,
  output logic [W-1:0] period,
  output logic [W-1:0] duty
);

  // state | meaning
  // IDLE  | silent, accumulator held at 0, waiting for a key event
  // BEEP  | tone playing for BEEP_CYCLES cycles, retriggered by any event

  localparam int TW = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(BEEP_CYCLES - 1);
  localparam logic [W-1:0]  P_BASE = W'(FREQ_BASE);
  localparam logic [W:0]    F_STEP = (W+1)'(FREQ_STEP);
  localparam logic [W:0]    V_STEP = (W+1)'(VOL_STEP);
  localparam logic [W:0]    SAT    = {1'b0, {W{1'b1}}};

  typedef enum logic {IDLE, BEEP} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [W-1:0]  acc;
  logic          key_event;
  logic          beep_done;
  logic          pwm;
  logic [W:0]    duty_up;
  logic [W:0]    duty_dn;
  logic [W:0]    period_up;
  logic [W:0]    period_dn;
  logic [W-1:0]  duty_nxt;
  logic [W-1:0]  period_nxt;

  assign key_event = key_flag && (key_value != 4'b1111);
  assign beep_done = (state == BEEP) && (timer == T_LAST);
  assign pwm       = acc < duty;

  // One extra bit so overflow and underflow show up before truncation.
  assign duty_up   = {1'b0, duty} + V_STEP;
  assign duty_dn   = {1'b0, duty} - V_STEP;
  assign period_up = {1'b0, period} + F_STEP;
  assign period_dn = {1'b0, period} - F_STEP;

  always_comb begin
    duty_nxt   = duty;
    period_nxt = period;
    if (!key_value[0]) begin
      duty_nxt = (duty_up > SAT) ? SAT[W-1:0] : duty_up[W-1:0];
    end else if (!key_value[1]) begin
      duty_nxt = (duty_dn[W] || (duty_dn < V_STEP)) ? V_STEP[W-1:0] : duty_dn[W-1:0];
    end else if (!key_value[2]) begin
      period_nxt = (period_up > SAT) ? SAT[W-1:0] : period_up[W-1:0];
    end else if (!key_value[3]) begin
      period_nxt = (period_dn[W] || (period_dn < F_STEP)) ? F_STEP[W-1:0] : period_dn[W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      timer  <= '0;
      acc    <= '0;
      period <= P_BASE;
      duty   <= V_STEP[W-1:0];
      buzzer <= 1'b1;
    end else begin
      buzzer <= ~(pwm & busy);
      if (key_event) begin
        period <= period_nxt;
        duty   <= duty_nxt;
        state  <= BEEP;
        busy   <= 1'b1;
        timer  <= '0;
        acc    <= (state == BEEP) ? acc + period : '0;
      end else if (state == BEEP) begin
        if (beep_done) begin
          state <= IDLE;
          busy  <= 1'b0;
          timer <= '0;
          acc   <= '0;
        end else begin
          timer <= timer + TW'(1);
          acc   <= acc + period;
        end
      end else begin
        acc <= '0;
      end
    end
  end

endmodule
